// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with registered or first-word-fall-through read,
// registered status flags derived from the next count, and sticky overflow/underflow.
module fifo_sync_param #(
  parameter int WIDTH        = 8,
  parameter int DEEP         = 16,
  parameter int ADRESS_WIDTH = 4,
  parameter int AF_LEVEL     = DEEP - 2,
  parameter int AE_LEVEL     = 2,
  parameter bit FWFT         = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    en_w,
  input  logic [WIDTH-1:0]        data_w,
  input  logic                    en_r,
  output logic [WIDTH-1:0]        data_r,
  output logic                    valid_r,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADRESS_WIDTH:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [ADRESS_WIDTH:0]   DEEP_C    = (ADRESS_WIDTH+1)'(DEEP);
  localparam logic [ADRESS_WIDTH:0]   AF_C      = (ADRESS_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADRESS_WIDTH:0]   AE_C      = (ADRESS_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADRESS_WIDTH:0]   CNT_ONE_C = (ADRESS_WIDTH+1)'(1);
  localparam logic [ADRESS_WIDTH-1:0] PTR_ONE_C = ADRESS_WIDTH'(1);

  logic [WIDTH-1:0]        mem_q [DEEP];
  logic [ADRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADRESS_WIDTH:0]   count_q, count_d;
  logic                    full_q, full_d, empty_q, empty_d;
  logic                    af_q, af_d, ae_q, ae_d;
  logic                    ovf_q, ovf_d, udf_q, udf_d;
  logic                    valid_r_q, valid_r_d;
  logic [WIDTH-1:0]        data_r_q, data_r_d;
  logic                    wr_acc_s, rd_acc_s;

  // Flush blocks both requests; a full FIFO still pops, an empty one still pushes.
  assign wr_acc_s = en_w && !full_q && !flush && !rst;
  assign rd_acc_s = en_r && !empty_q && !flush;

  // Next-state logic for pointers, count, read register and status flags
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    valid_r_d = 1'b0;
    data_r_d  = data_r_q;
    if (flush) begin
      wr_ptr_d  = {ADRESS_WIDTH{1'b0}};
      rd_ptr_d  = {ADRESS_WIDTH{1'b0}};
      count_d   = {(ADRESS_WIDTH+1){1'b0}};
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      valid_r_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE_C;
        valid_r_d = 1'b1;
        data_r_d  = mem_q[rd_ptr_q];
      end else begin
        rd_ptr_d  = rd_ptr_q;
        valid_r_d = 1'b0;
        data_r_d  = data_r_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (en_w & full_q);
      udf_d = udf_q | (en_r & empty_q);
    end
    // Flags follow the post-edge count so they need no extra cycle.
    full_d  = (count_d == DEEP_C);
    empty_d = (count_d == {(ADRESS_WIDTH+1){1'b0}});
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  // State registers with synchronous reset dominating everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {ADRESS_WIDTH{1'b0}};
      rd_ptr_q  <= {ADRESS_WIDTH{1'b0}};
      count_q   <= {(ADRESS_WIDTH+1){1'b0}};
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      valid_r_q <= 1'b0;
      data_r_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      valid_r_q <= valid_r_d;
      data_r_q  <= data_r_d;
    end
  end

  // Storage array; contents are left as-is on reset and flush
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= data_w;
    end
  end

  assign data_r       = FWFT ? (empty_q ? {WIDTH{1'b0}} : mem_q[rd_ptr_q]) : data_r_q;
  assign valid_r      = FWFT ? !empty_q : valid_r_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a registered-read and a fall-through instance share the
// same stimulus and are checked against one queue-based reference model.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0, flush = 1'b0, en_w = 1'b0, en_r = 1'b0;
  logic [7:0] data_w = 8'h00;

  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d1_valid;
  logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
  logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;
  logic [4:0] d0_count, d1_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEEP(16), .ADRESS_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .en_w(en_w), .data_w(data_w), .en_r(en_r),
    .data_r(d0_data), .valid_r(d0_valid), .full(d0_full), .empty(d0_empty),
    .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ovf), .underflow(d0_udf));

  fifo_sync_param #(.WIDTH(8), .DEEP(16), .ADRESS_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .en_w(en_w), .data_w(data_w), .en_r(en_r),
    .data_r(d1_data), .valid_r(d1_valid), .full(d1_full), .empty(d1_empty),
    .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ovf), .underflow(d1_udf));

  // One clock of stimulus; the reference queue is updated at the edge.
  task automatic step(input logic w, input logic [7:0] wd, input logic r,
                      input logic f, input logic rs);
    logic wacc, racc;
    @(negedge clk);
    en_w = w; data_w = wd; en_r = r; flush = f; rst = rs;
    @(posedge clk);
    if (rs) begin
      sb_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_data = 8'h00;
    end else if (f) begin
      sb_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0;
    end else begin
      wacc = w && (sb_q.size() < 16);
      racc = r && (sb_q.size() > 0);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_udf = 1'b1;
      m_valid = racc;
      if (racc) m_data = sb_q.pop_front();
      if (wacc) sb_q.push_back(wd);
    end
    m_count = sb_q.size();
    #1;
    en_w = 1'b0; en_r = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++;
    if ({d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_valid} !== 7'b0101000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0101000", {d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_valid});
    end
    total++;
    if (d0_count !== 5'd0 || d0_data !== 8'h00) begin
      bad++; $display("FAIL reset_count_data got=%0d/%h exp=0/00", d0_count, d0_data);
    end
    total++;
    if (d1_valid !== 1'b0 || d1_data !== 8'h00 || d1_empty !== 1'b1) begin
      bad++; $display("FAIL reset_fwft got=v%b d%h e%b exp=v0 d00 e1", d1_valid, d1_data, d1_empty);
    end
  endtask

  task automatic test_fill_drain();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      total++;
      if (d0_count !== 5'(i) || d0_valid !== 1'b0) begin
        bad++; $display("FAIL fill_count got=%0d v=%b exp=%0d v=0", d0_count, d0_valid, i);
      end
    end
    total++;
    if (d0_full !== 1'b1 || d0_af !== 1'b1) begin
      bad++; $display("FAIL fill_full got=%b af=%b exp=1 af=1", d0_full, d0_af);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++;
      if (d0_valid !== 1'b1 || d0_data !== m_data || d0_data !== 8'(i)) begin
        bad++; $display("FAIL drain_data got=v%b %h exp=v1 %h", d0_valid, d0_data, m_data);
      end
    end
    total++;
    if (d0_empty !== 1'b1 || d0_count !== 5'd0 || d0_udf !== 1'b0) begin
      bad++; $display("FAIL drain_empty got=e%b c%0d u%b exp=e1 c0 u0", d0_empty, d0_count, d0_udf);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++;
    if (d0_valid !== 1'b0 || d0_data !== 8'h10) begin
      bad++; $display("FAIL hold_data got=v%b %h exp=v0 10", d0_valid, d0_data);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    total++;
    if (d0_count !== 5'd15 || d0_ovf !== 1'b1 || d0_full !== 1'b0 || d0_data !== 8'h20) begin
      bad++; $display("FAIL ovf_cycle got=c%0d o%b f%b d%h exp=c15 o1 f0 d20", d0_count, d0_ovf, d0_full, d0_data);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++;
    if (d0_count !== 5'd15 || d0_ovf !== 1'b1 || d1_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=c%0d o%b/%b exp=c15 o1/1", d0_count, d0_ovf, d1_ovf);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++;
      if (d0_data !== m_data || d0_valid !== m_valid) begin
        bad++; $display("FAIL ovf_drain got=v%b %h exp=v%b %h", d0_valid, d0_data, m_valid, m_data);
      end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    total++;
    if (d0_udf !== 1'b1 || d0_count !== 5'd1 || d0_valid !== 1'b0 || d0_ovf !== 1'b0) begin
      bad++; $display("FAIL udf_cycle got=u%b c%0d v%b o%b exp=u1 c1 v0 o0", d0_udf, d0_count, d0_valid, d0_ovf);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (d0_valid !== 1'b1 || d0_data !== 8'hAA || d0_udf !== 1'b1) begin
      bad++; $display("FAIL udf_read got=v%b %h u%b exp=v1 aa u1", d0_valid, d0_data, d0_udf);
    end
  endtask

  task automatic test_fwft();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    total++;
    if (d1_valid !== 1'b1 || d1_data !== 8'h55) begin
      bad++; $display("FAIL fwft_show got=v%b %h exp=v1 55", d1_valid, d1_data);
    end
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    total++;
    if (d1_valid !== 1'b1 || d1_data !== 8'h55 || d1_count !== 5'd2) begin
      bad++; $display("FAIL fwft_hold got=v%b %h c%0d exp=v1 55 c2", d1_valid, d1_data, d1_count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (d1_valid !== 1'b1 || d1_data !== 8'h66) begin
      bad++; $display("FAIL fwft_next got=v%b %h exp=v1 66", d1_valid, d1_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (d1_valid !== 1'b0 || d1_empty !== 1'b1) begin
      bad++; $display("FAIL fwft_pop got=v%b e%b exp=v0 e1", d1_valid, d1_empty);
    end
  endtask

  task automatic test_wrap();
    int wn = 0;
    logic w, r;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    // 15 writes, 10 write+read, 15 reads, 8 writes, 7 write+read, 8 reads
    for (int c = 0; c < 63; c++) begin
      w = (c < 25) || (c >= 40 && c < 55);
      r = (c >= 15 && c < 40) || (c >= 48);
      step(w, 8'(wn * 7 + 3), r, 1'b0, 1'b0);
      if (w) wn++;
      total++;
      if ({d0_af, d0_ae, d1_af, d1_ae} !== {m_count >= 14, m_count <= 2, m_count >= 14, m_count <= 2}
          || d0_count !== 5'(m_count)) begin
        bad++; $display("FAIL wrap_flags c=%0d got=af%b ae%b cnt%0d exp_cnt=%0d", c, d0_af, d0_ae, d0_count, m_count);
      end
      if (m_valid) begin
        total++;
        if (d0_valid !== 1'b1 || d0_data !== m_data) begin
          bad++; $display("FAIL wrap_data c=%0d got=v%b %h exp=v1 %h", c, d0_valid, d0_data, m_data);
        end
      end
      if (m_count > 0) begin
        total++;
        if (d1_valid !== 1'b1 || d1_data !== sb_q[0]) begin
          bad++; $display("FAIL wrap_fwft c=%0d got=v%b %h exp=v1 %h", c, d1_valid, d1_data, sb_q[0]);
        end
      end
    end
    total++;
    if (wn !== 40 || d0_empty !== 1'b1 || d0_ovf !== 1'b0 || d0_udf !== 1'b0) begin
      bad++; $display("FAIL wrap_end got=e%b o%b u%b w%0d exp=e1 o0 u0 w40", d0_empty, d0_ovf, d0_udf, wn);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    total++;
    if ({d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_valid} !== 7'b0101000 || d0_count !== 5'd0) begin
      bad++; $display("FAIL flush_state got=%b c%0d exp=0101000 c0", {d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_valid}, d0_count);
    end
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (d0_data !== 8'h3C || d0_valid !== 1'b1 || d0_empty !== 1'b1) begin
      bad++; $display("FAIL flush_after got=v%b %h e%b exp=v1 3c e1", d0_valid, d0_data, d0_empty);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b1, 1'b1, 1'b1);
    total++;
    if ({d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_valid} !== 7'b0101000
        || d0_count !== 5'd0 || d0_data !== 8'h00) begin
      bad++; $display("FAIL rst_mid got=%b c%0d d%h exp=0101000 c0 d00", {d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_valid}, d0_count, d0_data);
    end
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    total++;
    if (d1_data !== 8'h77 || d1_count !== 5'd1) begin
      bad++; $display("FAIL rst_first_fwft got=%h c%0d exp=77 c1", d1_data, d1_count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (d0_data !== 8'h77 || d0_valid !== 1'b1) begin
      bad++; $display("FAIL rst_first got=v%b %h exp=v1 77", d0_valid, d0_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_fwft();
    test_wrap();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
